// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - two-port round-robin arbiter for the single VRAM port
// Optional ownership lock: define VRAM_ARB_LOCK_EN.
module vram_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_i,
  input  logic              we0_i,
  input  logic [ADDR_W-1:0] addr0_i,
  input  logic [DATA_W-1:0] wdata0_i,
  input  logic              lock0_i,
  input  logic              req1_i,
  input  logic              we1_i,
  input  logic [ADDR_W-1:0] addr1_i,
  input  logic [DATA_W-1:0] wdata1_i,
  input  logic              lock1_i,
  output logic              gnt0_o,
  output logic              gnt1_o,
  output logic              rvalid0_o,
  output logic              rvalid1_o,
  output logic [DATA_W-1:0] rdata0_o,
  output logic [DATA_W-1:0] rdata1_o,
  output logic              vram_we_o,
  output logic              vram_re_o,
  output logic [ADDR_W-1:0] vram_addr_o,
  output logic [DATA_W-1:0] vram_data_o,
  input  logic [DATA_W-1:0] vram_data_i
);

  // last_grant: 1 means port 1 won the most recent handshake
  logic              last_grant_q, last_grant_d;
  logic              lock_q, lock_d;
  logic              lock_owner_q, lock_owner_d;
  logic              lock_hold;
  logic              hs;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              vram_we_q, vram_re_q;
  logic [ADDR_W-1:0] vram_addr_q;
  logic [DATA_W-1:0] vram_data_q;
  logic [RD_LAT:0]   pipe_v_q;
  logic [RD_LAT:0]   pipe_tag_q;
  logic              rvalid0_q, rvalid1_q;
  logic [DATA_W-1:0] rdata0_q, rdata1_q;

`ifdef VRAM_ARB_LOCK_EN
  // lock is only honoured while its owner keeps requesting
  assign lock_hold = lock_q && (lock_owner_q ? req1_i : req0_i);
`else
  logic unused_lock;
  assign lock_hold   = 1'b0;
  assign unused_lock = ^{lock0_i, lock1_i};
`endif

  // Grant decision: lock owner first, then round-robin on contention
  always_comb begin
    gnt0_o = 1'b0;
    gnt1_o = 1'b0;
    if (lock_hold) begin
      gnt0_o = !lock_owner_q;
      gnt1_o = lock_owner_q;
    end else if (req0_i && req1_i) begin
      gnt0_o = last_grant_q;
      gnt1_o = !last_grant_q;
    end else begin
      gnt0_o = req0_i;
      gnt1_o = req1_i;
    end
    if (rst) begin
      gnt0_o = 1'b0;
      gnt1_o = 1'b0;
    end
  end

  assign hs        = gnt0_o || gnt1_o;
  assign sel_we    = gnt1_o ? we1_i    : we0_i;
  assign sel_addr  = gnt1_o ? addr1_i  : addr0_i;
  assign sel_wdata = gnt1_o ? wdata1_i : wdata0_i;

  // Next arbitration state: remember winner and its lock request
  always_comb begin
    last_grant_d = last_grant_q;
    lock_d       = lock_q;
    lock_owner_d = lock_owner_q;
    if (hs) begin
      last_grant_d = gnt1_o;
      lock_owner_d = gnt1_o;
      lock_d       = gnt1_o ? lock1_i : lock0_i;
    end else if (lock_q && !(lock_owner_q ? req1_i : req0_i)) begin
      lock_d = 1'b0;
    end
  end

  // Registered VRAM command, read-tag pipeline and read-data return
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= 1'b1;
      lock_q       <= 1'b0;
      lock_owner_q <= 1'b0;
      vram_we_q    <= 1'b0;
      vram_re_q    <= 1'b0;
      vram_addr_q  <= '0;
      vram_data_q  <= '0;
      pipe_v_q     <= '0;
      pipe_tag_q   <= '0;
      rvalid0_q    <= 1'b0;
      rvalid1_q    <= 1'b0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      lock_q       <= lock_d;
      lock_owner_q <= lock_owner_d;
      vram_we_q    <= hs && sel_we;
      vram_re_q    <= hs && !sel_we;
      if (hs) begin
        vram_addr_q <= sel_addr;
        vram_data_q <= sel_wdata;
      end
      // stage 0 lines up with vram_re_o; stage RD_LAT with valid vram_data_i
      pipe_v_q   <= {pipe_v_q[RD_LAT-1:0], hs && !sel_we};
      pipe_tag_q <= {pipe_tag_q[RD_LAT-1:0], gnt1_o};
      rvalid0_q  <= pipe_v_q[RD_LAT] && !pipe_tag_q[RD_LAT];
      rvalid1_q  <= pipe_v_q[RD_LAT] && pipe_tag_q[RD_LAT];
      if (pipe_v_q[RD_LAT] && !pipe_tag_q[RD_LAT]) rdata0_q <= vram_data_i;
      if (pipe_v_q[RD_LAT] && pipe_tag_q[RD_LAT])  rdata1_q <= vram_data_i;
    end
  end

  assign vram_we_o   = vram_we_q;
  assign vram_re_o   = vram_re_q;
  assign vram_addr_o = vram_addr_q;
  assign vram_data_o = vram_data_q;
  assign rvalid0_o   = rvalid0_q;
  assign rvalid1_o   = rvalid1_q;
  assign rdata0_o    = rdata0_q;
  assign rdata1_o    = rdata1_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// tb/tb_vram_arbiter.sv - bench for vram_arbiter (default build or VRAM_ARB_LOCK_EN)
module tb_vram_arbiter;
  localparam int AW   = 16;
  localparam int DW   = 8;
  localparam int L    = 1;
  localparam int MAXC = 8192;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req0, we0, lock0, req1, we1, lock1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0_o, gnt1_o, rvalid0_o, rvalid1_o;
  logic [DW-1:0] rdata0_o, rdata1_o;
  logic          vram_we_o, vram_re_o;
  logic [AW-1:0] vram_addr_o;
  logic [DW-1:0] vram_data_o, vram_data_i;

  vram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(L)) dut (
    .clk(clk), .rst(rst),
    .req0_i(req0), .we0_i(we0), .addr0_i(addr0), .wdata0_i(wdata0), .lock0_i(lock0),
    .req1_i(req1), .we1_i(we1), .addr1_i(addr1), .wdata1_i(wdata1), .lock1_i(lock1),
    .gnt0_o(gnt0_o), .gnt1_o(gnt1_o),
    .rvalid0_o(rvalid0_o), .rvalid1_o(rvalid1_o),
    .rdata0_o(rdata0_o), .rdata1_o(rdata1_o),
    .vram_we_o(vram_we_o), .vram_re_o(vram_re_o),
    .vram_addr_o(vram_addr_o), .vram_data_o(vram_data_o),
    .vram_data_i(vram_data_i)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
  endtask

  // Per-cycle history: handshakes, resets and the VRAM read bus
  bit            hs_v[MAXC], hs_p[MAXC], hs_we[MAXC], rst_h[MAXC];
  logic [AW-1:0] hs_a[MAXC];
  logic [DW-1:0] hs_d[MAXC], vdat[MAXC];
  bit            m_last, m_lock, m_owner;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data, m_rd0, m_rd1;

  initial begin
    m_last = 1'b1; m_lock = 1'b0; m_owner = 1'b0;
    m_addr = '0; m_data = '0; m_rd0 = '0; m_rd1 = '0;
  end

  // Compare DUT outputs against the history-based model every cycle
  always @(negedge clk) begin : compare
    int c, h;
    bit e0, e1, ewe, ere, erv0, erv1, ok, own_req;
    c = cyc;
    if (c >= MAXC) begin
      $display("FAIL cycle_budget: got %0d expected below %0d", c, MAXC);
      $fatal(1);
    end
    rst_h[c] = rst;
    vdat[c]  = vram_data_i;
    e0 = 0; e1 = 0; ewe = 0; ere = 0; erv0 = 0; erv1 = 0;
    if (rst) begin
      m_last = 1'b1; m_lock = 1'b0;
      m_addr = '0; m_data = '0; m_rd0 = '0; m_rd1 = '0;
      hs_v[c] = 1'b0;
    end else begin
      own_req = m_owner ? req1 : req0;
      if (m_lock && own_req) begin
        e0 = !m_owner; e1 = m_owner;
      end else if (req0 && req1) begin
        e0 = m_last; e1 = !m_last;
      end else begin
        e0 = req0; e1 = req1;
      end
      if (c > 0 && hs_v[c-1]) begin
        ewe = hs_we[c-1];
        ere = !hs_we[c-1];
        m_addr = hs_a[c-1];
        if (ewe) m_data = hs_d[c-1];
      end
      h = c - 2 - L;
      if (h >= 0 && hs_v[h] && !hs_we[h]) begin
        ok = 1;
        for (int k = h; k <= c; k++) if (rst_h[k]) ok = 0;
        if (ok) begin
          if (hs_p[h]) begin erv1 = 1; m_rd1 = vdat[c-1]; end
          else begin erv0 = 1; m_rd0 = vdat[c-1]; end
        end
      end
      hs_v[c]  = e0 || e1;
      hs_p[c]  = e1;
      hs_we[c] = e1 ? we1 : we0;
      hs_a[c]  = e1 ? addr1 : addr0;
      hs_d[c]  = e1 ? wdata1 : wdata0;
      if (e0 || e1) begin
        m_last  = e1;
        m_owner = e1;
`ifdef VRAM_ARB_LOCK_EN
        m_lock  = e1 ? lock1 : lock0;
`endif
      end else if (m_lock && !own_req) begin
        m_lock = 1'b0;
      end
    end
    chk("gnt0", gnt0_o, e0);
    chk("gnt1", gnt1_o, e1);
    chk("vram_we", vram_we_o, ewe);
    chk("vram_re", vram_re_o, ere);
    chk("vram_addr", vram_addr_o, m_addr);
    if (ewe || rst) chk("vram_data", vram_data_o, m_data);
    chk("rvalid0", rvalid0_o, erv0);
    chk("rvalid1", rvalid1_o, erv1);
    chk("rdata0", rdata0_o, m_rd0);
    chk("rdata1", rdata1_o, m_rd1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit s0, s1;
    req0 = 0; we0 = 0; lock0 = 0; addr0 = '0; wdata0 = '0;
    req1 = 0; we1 = 0; lock1 = 0; addr1 = '0; wdata1 = '0;
    vram_data_i = '0;
    repeat (3) tick();
    rst = 0;

    // reset while a read is in flight
    req0 = 1; we0 = 0; addr0 = 16'h0bad;
    @(negedge clk); chk("rst_first_gnt0", gnt0_o, 1);
    tick(); req0 = 0; vram_data_i = 8'h77;
    @(negedge clk); chk("rst_pre_re", vram_re_o, 1);
    tick(); rst = 1;
    @(negedge clk); chk("rst_re_low", vram_re_o, 0); chk("rst_addr_zero", vram_addr_o, 0);
    tick(); rst = 0; vram_data_i = '0;
    repeat (3) begin
      @(negedge clk); chk("rst_no_rvalid0", rvalid0_o, 0);
      tick();
    end

    // contention: port 0 first after reset, then alternation
    req0 = 1; req1 = 1; we0 = 0; we1 = 0; addr0 = 16'h0100; addr1 = 16'h0200;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("cont_gnt0", gnt0_o, (i % 2 == 0));
      chk("cont_gnt1", gnt1_o, (i % 2 == 1));
      tick();
      if (i % 2 == 0) addr0 = addr0 + 1; else addr1 = addr1 + 1;
    end
    req0 = 0; req1 = 0;
    repeat (4) tick();

    // single read
    req0 = 1; we0 = 0; addr0 = 16'h1234;
    @(negedge clk); chk("rd_gnt0", gnt0_o, 1); chk("rd_gnt1", gnt1_o, 0);
    tick(); req0 = 0;
    @(negedge clk); chk("rd_re", vram_re_o, 1); chk("rd_we", vram_we_o, 0); chk("rd_addr", vram_addr_o, 16'h1234);
    tick(); vram_data_i = 8'hA5;
    @(negedge clk); chk("rd_early_rvalid0", rvalid0_o, 0);
    tick(); vram_data_i = 8'h00;
    @(negedge clk); chk("rd_rvalid0", rvalid0_o, 1); chk("rd_rdata0", rdata0_o, 8'hA5); chk("rd_rvalid1", rvalid1_o, 0);
    tick();
    @(negedge clk); chk("rd_strobe_ends", rvalid0_o, 0); chk("rd_rdata0_hold", rdata0_o, 8'hA5);

    // write from port 1 to the top address
    tick(); req1 = 1; we1 = 1; addr1 = 16'hFFFF; wdata1 = 8'h3C;
    @(negedge clk); chk("wr_gnt1", gnt1_o, 1);
    tick(); req1 = 0;
    @(negedge clk); chk("wr_we", vram_we_o, 1); chk("wr_re", vram_re_o, 0);
    chk("wr_addr", vram_addr_o, 16'hFFFF); chk("wr_data", vram_data_o, 8'h3C);
    tick();
    @(negedge clk); chk("wr_we_idle", vram_we_o, 0); chk("wr_addr_hold", vram_addr_o, 16'hFFFF);
    repeat (3) begin
      tick();
      @(negedge clk); chk("wr_no_rvalid1", rvalid1_o, 0);
    end

    // interleaved reads
    tick(); req0 = 1; we0 = 0; addr0 = 16'h0010; req1 = 1; we1 = 0; addr1 = 16'h0020;
    @(negedge clk); chk("il_gnt0", gnt0_o, 1);
    tick(); req0 = 0;
    @(negedge clk); chk("il_gnt1", gnt1_o, 1); chk("il_addr0", vram_addr_o, 16'h0010);
    tick(); req1 = 0; vram_data_i = 8'h11;
    @(negedge clk); chk("il_addr1", vram_addr_o, 16'h0020); chk("il_re", vram_re_o, 1);
    tick(); vram_data_i = 8'h22;
    @(negedge clk); chk("il_rvalid0", rvalid0_o, 1); chk("il_rdata0", rdata0_o, 8'h11); chk("il_rvalid1_early", rvalid1_o, 0);
    tick(); vram_data_i = 8'h00;
    @(negedge clk); chk("il_rvalid1", rvalid1_o, 1); chk("il_rdata1", rdata1_o, 8'h22); chk("il_rvalid0_late", rvalid0_o, 0);
    repeat (3) tick();

`ifdef VRAM_ARB_LOCK_EN
    // port 1 locks for four accesses, then releases
    req1 = 1; we1 = 1; lock1 = 1; addr1 = 16'h4000; wdata1 = 8'h5A;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); chk("lk_gnt1", gnt1_o, 1); chk("lk_gnt0", gnt0_o, 0);
      tick();
      req0 = 1; we0 = 0; addr0 = 16'h5000;
      addr1 = addr1 + 1;
    end
    lock1 = 0;
    @(negedge clk); chk("lk_release_gnt1", gnt1_o, 1);
    tick();
    @(negedge clk); chk("lk_after_gnt0", gnt0_o, 1); chk("lk_after_gnt1", gnt1_o, 0);
    tick(); req0 = 0; req1 = 0;
    repeat (3) tick();
`endif

    // randomized traffic with occasional resets
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk); s0 = gnt0_o; s1 = gnt1_o;
      tick();
      rst = ($urandom_range(0, 299) == 0);
      if (!req0 || s0) begin
        req0 = ($urandom_range(0, 2) != 0); we0 = 1'($urandom);
        addr0 = 16'($urandom); wdata0 = 8'($urandom); lock0 = ($urandom_range(0, 3) == 0);
      end
      if (!req1 || s1) begin
        req1 = ($urandom_range(0, 2) != 0); we1 = 1'($urandom);
        addr1 = 16'($urandom); wdata1 = 8'($urandom); lock1 = ($urandom_range(0, 3) == 0);
      end
      vram_data_i = 8'($urandom);
    end
    rst = 0; req0 = 0; req1 = 0;
    repeat (6) tick();
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
